// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
// Widths here are the defaults used by the top, the scoreboard and the interface.
package rf_wb_arbiter_pkg;

  localparam int RfDataWidth    = 64;
  localparam int RfAddrWidth    = 5;
  localparam int RfRegNum       = 32;
  localparam int MaxWaitDefault = 4;
  localparam int WaitCntWidth   = 4;

  // Address of the hardwired-zero register x0.
  localparam logic [RfAddrWidth-1:0] RegZero = '0;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB0  = 2'd1,
    GRANT_WB1  = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback requests, issue/flush controls and the RF write port.
// Handshake: a request transfers in a cycle where Valid && Ready; the requester
// holds Valid/Addr/Data stable until then, and Ready never depends on a later cycle.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DataWidth = RfDataWidth,
  parameter int AddrWidth = RfAddrWidth,
  parameter int RegNum    = RfRegNum
);

  logic                    Wb0Valid;
  logic [AddrWidth-1:0]    Wb0Addr;
  logic [DataWidth-1:0]    Wb0Data;
  logic                    Wb0Ready;
  logic                    Wb1Valid;
  logic [AddrWidth-1:0]    Wb1Addr;
  logic [DataWidth-1:0]    Wb1Data;
  logic                    Wb1Ready;
  logic                    IssueValid;
  logic [AddrWidth-1:0]    IssueAddr;
  logic                    Flush;
  logic                    RdWriteEnable;
  logic [AddrWidth-1:0]    RdWriteAddr;
  logic [DataWidth-1:0]    RdWriteData;
  logic [RegNum-1:0]       BusyMask;
  // Debug view of the starvation counter.
  logic [WaitCntWidth-1:0] WaitCnt;

  modport master (
    output Wb0Valid, Wb0Addr, Wb0Data, Wb1Valid, Wb1Addr, Wb1Data,
    output IssueValid, IssueAddr, Flush,
    input  Wb0Ready, Wb1Ready, RdWriteEnable, RdWriteAddr, RdWriteData,
    input  BusyMask, WaitCnt
  );

  modport slave (
    input  Wb0Valid, Wb0Addr, Wb0Data, Wb1Valid, Wb1Addr, Wb1Data,
    input  IssueValid, IssueAddr, Flush,
    output Wb0Ready, Wb1Ready, RdWriteEnable, RdWriteAddr, RdWriteData,
    output BusyMask, WaitCnt
  );

endinterface

// File: rtl/rf_busy_scoreboard.sv
// Per-register busy bitmap for destinations owed by the long-latency unit.
// Set beats same-cycle clear (new owner); flush beats everything; bit 0 stays 0.
module rf_busy_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int AddrWidth = RfAddrWidth,
  parameter int RegNum    = RfRegNum
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 set_valid,
  input  logic [AddrWidth-1:0] set_addr,
  input  logic                 clr_valid,
  input  logic [AddrWidth-1:0] clr_addr,
  input  logic                 flush,
  output logic [RegNum-1:0]    busy_mask
);

  logic [RegNum-1:0] busy_next;

  always_comb begin
    busy_next = busy_mask;
    // Loop starts at 1 so x0 can never be marked busy.
    for (int i = 1; i < RegNum; i++) begin
      if (clr_valid && (clr_addr == AddrWidth'(i))) busy_next[i] = 1'b0;
      if (set_valid && (set_addr == AddrWidth'(i))) busy_next[i] = 1'b1;
    end
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) busy_mask <= '0;
    else      busy_mask <= busy_next;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file write port arbiter with anti-starvation for WB1
// and a busy scoreboard of WB1-owed destinations for decode RAW stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DataWidth = RfDataWidth,
  parameter int AddrWidth = RfAddrWidth,
  parameter int RegNum    = RfRegNum,
  parameter int MaxWait   = MaxWaitDefault
) (
  input logic Clk,
  input logic Rst,
  rf_wb_arbiter_if.slave bus
);

  grant_e                  grant;
  logic [WaitCntWidth-1:0] wait_cnt;
  logic                    at_limit;
  logic                    wr_en_q;
  logic [AddrWidth-1:0]    wr_addr_q;
  logic [DataWidth-1:0]    wr_data_q;
  logic [RegNum-1:0]       busy_mask;

  assign at_limit = (wait_cnt == WaitCntWidth'(MaxWait));

  // WB0 wins by default; WB1 takes the port when alone or once starved MaxWait cycles.
  always_comb begin
    grant = GRANT_NONE;
    if (!Rst)                                          grant = GRANT_NONE;
    else if (bus.Wb1Valid && (!bus.Wb0Valid || at_limit)) grant = GRANT_WB1;
    else if (bus.Wb0Valid)                             grant = GRANT_WB0;
  end

  assign bus.Wb0Ready = (grant == GRANT_WB0);
  assign bus.Wb1Ready = (grant == GRANT_WB1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (!bus.Wb1Valid || (grant == GRANT_WB1)) wait_cnt <= '0;
      else if (!at_limit)                        wait_cnt <= wait_cnt + 1'b1;

      wr_en_q <= 1'b0;
      case (grant)
        GRANT_WB0: begin
          wr_en_q   <= (bus.Wb0Addr != RegZero);
          wr_addr_q <= bus.Wb0Addr;
          wr_data_q <= bus.Wb0Data;
        end
        GRANT_WB1: begin
          wr_en_q   <= (bus.Wb1Addr != RegZero);
          wr_addr_q <= bus.Wb1Addr;
          wr_data_q <= bus.Wb1Data;
        end
        default: ;
      endcase
    end
  end

  rf_busy_scoreboard #(
    .AddrWidth (AddrWidth),
    .RegNum    (RegNum)
  ) u_scoreboard (
    .Clk       (Clk),
    .Rst       (Rst),
    .set_valid (bus.IssueValid),
    .set_addr  (bus.IssueAddr),
    .clr_valid (grant == GRANT_WB1),
    .clr_addr  (bus.Wb1Addr),
    .flush     (bus.Flush),
    .busy_mask (busy_mask)
  );

  assign bus.RdWriteEnable = wr_en_q;
  assign bus.RdWriteAddr   = wr_addr_q;
  assign bus.RdWriteData   = wr_data_q;
  assign bus.BusyMask      = busy_mask;
  assign bus.WaitCnt       = wait_cnt;

endmodule
